// File: rtl/argmax_select_pkg.sv
// Shared definitions for the classifier result path: sequencer states and
// default word widths.
package argmax_select_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CLS_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/argmax_select_top2.sv
// Running top-2 tracker. Scores are signed; strict greater-than keeps the
// earliest index on ties. The second slot starts at the most-negative value
// so a lone score leaves it pointing at index 0.
module top2_tracker
  import argmax_select_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CLS_W  = CLS_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              vld_i,
  input  logic              first_i,
  input  logic [CLS_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] score_i,
  output logic [CLS_W-1:0]  top1_class_o,
  output logic [DATA_W-1:0] top1_score_o,
  output logic [CLS_W-1:0]  top2_class_o
);

  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] score_s;
  logic signed [DATA_W-1:0] top1_s_q;
  logic signed [DATA_W-1:0] top2_s_q;

  assign score_s      = score_i;
  assign top1_score_o = top1_s_q;

  // Compare each arriving score against both slots and insert it.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      top1_class_o <= '0;
      top1_s_q     <= '0;
      top2_class_o <= '0;
      top2_s_q     <= '0;
    end else if (vld_i) begin
      if (first_i) begin
        top1_class_o <= idx_i;
        top1_s_q     <= score_s;
        top2_class_o <= '0;
        top2_s_q     <= SCORE_MIN;
      end else if (score_s > top1_s_q) begin
        top2_class_o <= top1_class_o;
        top2_s_q     <= top1_s_q;
        top1_class_o <= idx_i;
        top1_s_q     <= score_s;
      end else if (score_s > top2_s_q) begin
        top2_class_o <= idx_i;
        top2_s_q     <= score_s;
      end
    end
  end

endmodule

// File: rtl/argmax_select.sv
// Drains one frame of class scores from a non-showahead FIFO and reports the
// top-2 classes. A start pulse in any state aborts the current frame.
//   state   | meaning
//   IDLE    | no frame in progress
//   READ    | issuing FIFO reads and folding scores into the tracker
//   HOLD    | result presented, waiting for downstream accept
module argmax_select
  import argmax_select_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CLS_W  = CLS_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CLS_W-1:0]  classes_i,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  output logic [CLS_W-1:0]  top1_class_o,
  output logic [DATA_W-1:0] top1_score_o,
  output logic [CLS_W-1:0]  top2_class_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              busy_o
);

  state_e state_q;
  state_e state_d;

  logic [CLS_W-1:0] cls_cfg_q;
  // One extra bit so the read window closes even at the maximum class count.
  logic [CLS_W:0]   issued_q;
  logic [CLS_W-1:0] rx_idx_q;
  logic             data_vld_q;
  logic             last_rx;
  logic             rd_window;

  assign rd_window = (issued_q <= {1'b0, cls_cfg_q});
  assign last_rx   = data_vld_q && (rx_idx_q == cls_cfg_q);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start wins over every other transition.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = ST_READ;
    end else begin
      case (state_q)
        ST_READ: if (last_rx)        state_d = ST_HOLD;
        ST_HOLD: if (result_ready_i) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs: no read on a start or reset cycle, so an aborted frame cannot
  // consume a score belonging to the next one.
  always_comb begin
    fifo_rd_en_o   = 1'b0;
    result_valid_o = 1'b0;
    busy_o         = 1'b0;
    case (state_q)
      ST_READ: begin
        busy_o       = 1'b1;
        fifo_rd_en_o = !fifo_empty_i && rd_window && !start_i && !rst_i;
      end
      ST_HOLD: begin
        busy_o         = 1'b1;
        result_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Config latch, issued-read count, data-valid pipe and received index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cls_cfg_q  <= '0;
      issued_q   <= '0;
      rx_idx_q   <= '0;
      data_vld_q <= 1'b0;
    end else if (start_i) begin
      cls_cfg_q  <= classes_i;
      issued_q   <= '0;
      rx_idx_q   <= '0;
      data_vld_q <= 1'b0;
    end else begin
      data_vld_q <= fifo_rd_en_o;
      if (fifo_rd_en_o) issued_q <= issued_q + 1'b1;
      if (data_vld_q)   rx_idx_q <= rx_idx_q + 1'b1;
    end
  end

  top2_tracker #(
    .DATA_W (DATA_W),
    .CLS_W  (CLS_W)
  ) u_top2 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start_i),
    .vld_i        (data_vld_q),
    .first_i      (rx_idx_q == '0),
    .idx_i        (rx_idx_q),
    .score_i      (fifo_rd_data_i),
    .top1_class_o (top1_class_o),
    .top1_score_o (top1_score_o),
    .top2_class_o (top2_class_o)
  );

endmodule

// File: tb/tb_argmax_select.sv
// Testbench for argmax_select: queue-based FIFO model, scenario tasks,
// top-2 reference computed directly from the score list.
module tb_argmax_select;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [9:0] classes_i = '0;
  logic [7:0] fifo_rd_data_i = '0;
  logic       fifo_empty_i = 1'b1;
  logic       fifo_rd_en_o;
  logic [9:0] top1_class_o;
  logic [7:0] top1_score_o;
  logic [9:0] top2_class_o;
  logic       result_valid_o;
  logic       result_ready_i = 1'b0;
  logic       busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] frame_q[$];
  int  exp_scores[$];
  int  cyc = 0;
  int  rd_count = 0;
  int  last_rd_cyc = 0;
  bit  rd_when_empty = 0;
  bit  stall_en = 0;

  argmax_select dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .classes_i      (classes_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .top1_class_o   (top1_class_o),
    .top1_score_o   (top1_score_o),
    .top2_class_o   (top2_class_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Non-showahead FIFO: data appears the cycle after the read request.
  always @(posedge clk_i) begin
    if (fifo_rd_en_o) begin
      rd_count++;
      last_rd_cyc = cyc;
      if (fifo_empty_i) rd_when_empty = 1;
      if (frame_q.size() > 0) fifo_rd_data_i <= frame_q.pop_front();
    end
    cyc++;
  end

  always @(negedge clk_i)
    fifo_empty_i = (frame_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));

  // Reference: top1 is the earliest maximum; top2 is the earliest maximum of
  // the remaining scores, counting only scores above -128 (else index 0).
  task automatic model(output int t1c, output int t1s, output int t2c);
    int s2;
    t1c = 0;
    foreach (exp_scores[i]) if (exp_scores[i] > exp_scores[t1c]) t1c = i;
    t1s = exp_scores[t1c];
    t2c = 0;
    s2  = -128;
    foreach (exp_scores[i]) if (i != t1c && exp_scores[i] > s2) begin
      s2  = exp_scores[i];
      t2c = i;
    end
  endtask

  task automatic gen_scores(input int n);
    exp_scores.delete();
    for (int i = 0; i < n; i++) exp_scores.push_back(int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic load_fifo();
    frame_q.delete();
    foreach (exp_scores[i]) frame_q.push_back(8'(exp_scores[i]));
    for (int i = 0; i < 3; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    rd_count = 0;
    rd_when_empty = 0;
  endtask

  task automatic wait_valid(input int budget, output bit timeout);
    timeout = 1;
    for (int k = 0; k < budget; k++) begin
      if (result_valid_o) begin
        timeout = 0;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic run_frame(input int n, input bit stall, output int res_cyc, output bit timeout);
    stall_en = stall;
    load_fifo();
    start_i   = 1;
    classes_i = 10'(n - 1);
    @(negedge clk_i);
    start_i = 0;
    wait_valid(n * 8 + 50, timeout);
    res_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({fifo_rd_en_o, result_valid_o, busy_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: rd_en/valid/busy=%b required 000", {fifo_rd_en_o, result_valid_o, busy_o});
    end
    vectors++;
    if ({top1_class_o, top1_score_o, top2_class_o} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_data: top1=(%0d,%0d) top2=%0d required all 0", top1_class_o, top1_score_o, top2_class_o);
    end
    rst_i = 0;
    @(negedge clk_i);
  endtask

  task automatic accept(input string name);
    result_ready_i = 1;
    @(negedge clk_i);
    result_ready_i = 0;
    vectors++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_accept: valid=%b busy=%b required 0 0", name, result_valid_o, busy_o);
    end
    frame_q.delete();
    @(negedge clk_i);
  endtask

  // Fixed frames with hand-derived answers, including the single-class case.
  task automatic test_fixed_frames();
    int rc;
    bit to;
    exp_scores = '{3, -5, 20, 7, 20, 0, 1, 2, -1, 19};
    run_frame(10, 0, rc, to);
    vectors++;
    if (to || top1_class_o !== 10'd2 || $signed(top1_score_o) !== 8'sd20 || top2_class_o !== 10'd4) begin
      miscompares++;
      $display("FAIL ten_class: to=%0b top1=(%0d,%0d) top2=%0d required (2,20) 4", to, top1_class_o, $signed(top1_score_o), top2_class_o);
    end
    vectors++;
    if (rc - last_rd_cyc !== 2 || rd_count !== 10) begin
      miscompares++;
      $display("FAIL ten_class_latency: valid-rd_en=%0d reads=%0d required 2 10", rc - last_rd_cyc, rd_count);
    end
    accept("ten_class");

    exp_scores = '{-128, -100, -100, -128};
    run_frame(4, 0, rc, to);
    vectors++;
    if (to || top1_class_o !== 10'd1 || $signed(top1_score_o) !== -8'sd100 || top2_class_o !== 10'd2) begin
      miscompares++;
      $display("FAIL neg_ties: to=%0b top1=(%0d,%0d) top2=%0d required (1,-100) 2", to, top1_class_o, $signed(top1_score_o), top2_class_o);
    end
    accept("neg_ties");

    exp_scores = '{55};
    run_frame(1, 0, rc, to);
    vectors++;
    if (to || top1_class_o !== 10'd0 || $signed(top1_score_o) !== 8'sd55 || top2_class_o !== 10'd0 || rd_count !== 1) begin
      miscompares++;
      $display("FAIL one_class: to=%0b top1=(%0d,%0d) top2=%0d reads=%0d required (0,55) 0 1", to, top1_class_o, $signed(top1_score_o), top2_class_o, rd_count);
    end
    accept("one_class");
  endtask

  // 1000 classes with random FIFO gaps and a slow consumer.
  task automatic test_long_stall();
    int rc, t1c, t1s, t2c, rd_snap;
    bit to, stable;
    logic [27:0] snap;
    gen_scores(1000);
    model(t1c, t1s, t2c);
    run_frame(1000, 1, rc, to);
    vectors++;
    if (to || top1_class_o !== 10'(t1c) || $signed(top1_score_o) !== 8'(t1s) || top2_class_o !== 10'(t2c)) begin
      miscompares++;
      $display("FAIL long_result: to=%0b top1=(%0d,%0d) top2=%0d required (%0d,%0d) %0d", to, top1_class_o, $signed(top1_score_o), top2_class_o, t1c, t1s, t2c);
    end
    vectors++;
    if (rd_count !== 1000 || rd_when_empty) begin
      miscompares++;
      $display("FAIL long_reads: reads=%0d rd_when_empty=%0b required 1000 0", rd_count, rd_when_empty);
    end
    snap = {top1_class_o, top1_score_o, top2_class_o};
    rd_snap = rd_count;
    stable = 1;
    repeat (20) begin
      @(negedge clk_i);
      if ({top1_class_o, top1_score_o, top2_class_o} !== snap || result_valid_o !== 1'b1 || busy_o !== 1'b1) stable = 0;
    end
    vectors++;
    if (!stable || rd_count !== rd_snap) begin
      miscompares++;
      $display("FAIL long_hold: stable=%0b reads=%0d required 1 %0d", stable, rd_count, rd_snap);
    end
    stall_en = 0;
    accept("long");
  endtask

  // Restart at the 5th read of a 10-class frame with a 4-class frame.
  task automatic test_abort();
    int t1c, t1s, t2c;
    bit to, seen_valid;
    gen_scores(10);
    stall_en = 0;
    load_fifo();
    start_i = 1;
    classes_i = 10'd9;
    @(negedge clk_i);
    start_i = 0;
    to = 1;
    seen_valid = 0;
    for (int k = 0; k < 50; k++) begin
      if (result_valid_o) seen_valid = 1;
      if (rd_count >= 4) begin
        to = 0;
        break;
      end
      @(negedge clk_i);
    end
    vectors++;
    if (to || seen_valid || result_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_first: to=%0b valid_seen=%0b required 0 0", to, seen_valid | result_valid_o);
    end
    gen_scores(4);
    model(t1c, t1s, t2c);
    load_fifo();
    start_i = 1;
    classes_i = 10'd3;
    @(negedge clk_i);
    start_i = 0;
    wait_valid(80, to);
    vectors++;
    if (to || rd_count !== 4 || top1_class_o !== 10'(t1c) || $signed(top1_score_o) !== 8'(t1s) || top2_class_o !== 10'(t2c)) begin
      miscompares++;
      $display("FAIL abort_second: to=%0b reads=%0d top1=(%0d,%0d) top2=%0d required 4 (%0d,%0d) %0d", to, rd_count, top1_class_o, $signed(top1_score_o), top2_class_o, t1c, t1s, t2c);
    end
    accept("abort");
  endtask

  // Reset during READ discards the frame and stops reads.
  task automatic test_reset_mid();
    bit to, leak;
    int rd_snap;
    gen_scores(10);
    stall_en = 0;
    load_fifo();
    start_i = 1;
    classes_i = 10'd9;
    @(negedge clk_i);
    start_i = 0;
    to = 1;
    for (int k = 0; k < 50; k++) begin
      if (rd_count >= 3) begin
        to = 0;
        break;
      end
      @(negedge clk_i);
    end
    rst_i = 1;
    @(negedge clk_i);
    vectors++;
    if (to || {fifo_rd_en_o, result_valid_o, busy_o, top1_class_o, top1_score_o, top2_class_o} !== 31'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: to=%0b rd_en=%b valid=%b busy=%b top1=(%0d,%0d) top2=%0d required all 0", to, fifo_rd_en_o, result_valid_o, busy_o, top1_class_o, top1_score_o, top2_class_o);
    end
    rst_i = 0;
    rd_snap = rd_count;
    leak = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (result_valid_o !== 1'b0 || busy_o !== 1'b0) leak = 1;
    end
    vectors++;
    if (leak || rd_count !== rd_snap) begin
      miscompares++;
      $display("FAIL midreset_idle: leak=%0b reads=%0d required 0 %0d", leak, rd_count, rd_snap);
    end
    frame_q.delete();
    @(negedge clk_i);
  endtask

  // Start together with ready while holding a result: the new frame wins.
  task automatic test_back_to_back();
    int rc, t1c, t1s, t2c;
    bit to;
    gen_scores(6);
    model(t1c, t1s, t2c);
    run_frame(6, 1, rc, to);
    vectors++;
    if (to || top1_class_o !== 10'(t1c) || $signed(top1_score_o) !== 8'(t1s) || top2_class_o !== 10'(t2c)) begin
      miscompares++;
      $display("FAIL b2b_first: to=%0b top1=(%0d,%0d) top2=%0d required (%0d,%0d) %0d", to, top1_class_o, $signed(top1_score_o), top2_class_o, t1c, t1s, t2c);
    end
    gen_scores(5);
    model(t1c, t1s, t2c);
    load_fifo();
    start_i = 1;
    result_ready_i = 1;
    classes_i = 10'd4;
    @(negedge clk_i);
    start_i = 0;
    result_ready_i = 0;
    vectors++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_start_wins: valid=%b busy=%b required 0 1", result_valid_o, busy_o);
    end
    wait_valid(100, to);
    vectors++;
    if (to || rd_count !== 5 || top1_class_o !== 10'(t1c) || $signed(top1_score_o) !== 8'(t1s) || top2_class_o !== 10'(t2c)) begin
      miscompares++;
      $display("FAIL b2b_second: to=%0b reads=%0d top1=(%0d,%0d) top2=%0d required 5 (%0d,%0d) %0d", to, rd_count, top1_class_o, $signed(top1_score_o), top2_class_o, t1c, t1s, t2c);
    end
    stall_en = 0;
    accept("b2b");
  endtask

  task automatic test_random_frames();
    int rc, n, t1c, t1s, t2c;
    bit to;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 40);
      gen_scores(n);
      model(t1c, t1s, t2c);
      run_frame(n, f[0], rc, to);
      repeat ($urandom_range(0, 4)) @(negedge clk_i);
      vectors++;
      if (to || rd_count !== n || rd_when_empty || top1_class_o !== 10'(t1c) || $signed(top1_score_o) !== 8'(t1s) || top2_class_o !== 10'(t2c)) begin
        miscompares++;
        $display("FAIL random_%0d: to=%0b reads=%0d top1=(%0d,%0d) top2=%0d required %0d (%0d,%0d) %0d", f, to, rd_count, top1_class_o, $signed(top1_score_o), top2_class_o, n, t1c, t1s, t2c);
      end
      stall_en = 0;
      accept("random");
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_fixed_frames();
    test_long_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
